// File: rtl/multiciclo_datapath_regs.sv
// Architectural registers of the multicycle datapath: PC, PC backup, IR, MDR, A, B, ALUOut.
// Define MULTICICLO_COUNTERS_EN to add the oCycleCount / oInstret performance counters.
module multiciclo_datapath_regs #(
  parameter logic [31:0] PC_RESET = 32'h0040_0000
) (
  input  logic        iCLK,
  input  logic        iRST,
  input  logic        EscrevePC,
  input  logic        EscrevePCCond,
  input  logic        EscreveIR,
  input  logic        EscrevePCB,
  input  logic        OrigPC,
  input  logic        iZero,
  input  logic [31:0] iALUResult,
  input  logic [31:0] iMemData,
  input  logic [31:0] iRs1Data,
  input  logic [31:0] iRs2Data,
  output logic [31:0] oPC,
  output logic [31:0] oPCBack,
  output logic [31:0] oIR,
  output logic [31:0] oMDR,
  output logic [31:0] oA,
  output logic [31:0] oB,
  output logic [31:0] oALUOut
`ifdef MULTICICLO_COUNTERS_EN
  ,
  output logic [31:0] oCycleCount,
  output logic [31:0] oInstret
`endif
);

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        pcWrite;
  logic [31:0] pcSource;
  logic [31:0] pcNext;

  // Unconditional write dominates, so iZero only matters for a pure branch.
  assign pcWrite  = EscrevePC | (EscrevePCCond & iZero);
  assign pcSource = OrigPC ? oALUOut : iALUResult;
  assign pcNext   = {pcSource[31:1], 1'b0};

  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      oPC     <= PC_RESET;
      oPCBack <= PC_RESET;
      oIR     <= NOP;
      oMDR    <= '0;
      oA      <= '0;
      oB      <= '0;
      oALUOut <= '0;
    end else begin
      // oPCBack samples the PC value from before this edge's update.
      if (EscrevePCB) oPCBack <= oPC;
      if (pcWrite)    oPC     <= pcNext;
      if (EscreveIR)  oIR     <= iMemData;
      oMDR    <= iMemData;
      oA      <= iRs1Data;
      oB      <= iRs2Data;
      oALUOut <= iALUResult;
    end
  end

`ifdef MULTICICLO_COUNTERS_EN
  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      oCycleCount <= '0;
      oInstret    <= '0;
    end else begin
      oCycleCount <= oCycleCount + 32'd1;
      if (EscreveIR) oInstret <= oInstret + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_multiciclo_datapath_regs.sv
// Directed bench for multiciclo_datapath_regs: an abstract register model checked every
// negative edge, plus literal expectations for the documented scenarios.
module tb_multiciclo_datapath_regs;

  logic        iCLK = 1'b0;
  logic        iRST;
  logic        EscrevePC, EscrevePCCond, EscreveIR, EscrevePCB, OrigPC, iZero;
  logic [31:0] iALUResult, iMemData, iRs1Data, iRs2Data;
  logic [31:0] oPC, oPCBack, oIR, oMDR, oA, oB, oALUOut;
`ifdef MULTICICLO_COUNTERS_EN
  logic [31:0] oCycleCount, oInstret;
`endif

  multiciclo_datapath_regs dut (
    .iCLK(iCLK), .iRST(iRST),
    .EscrevePC(EscrevePC), .EscrevePCCond(EscrevePCCond), .EscreveIR(EscreveIR),
    .EscrevePCB(EscrevePCB), .OrigPC(OrigPC), .iZero(iZero),
    .iALUResult(iALUResult), .iMemData(iMemData), .iRs1Data(iRs1Data), .iRs2Data(iRs2Data),
    .oPC(oPC), .oPCBack(oPCBack), .oIR(oIR), .oMDR(oMDR), .oA(oA), .oB(oB), .oALUOut(oALUOut)
`ifdef MULTICICLO_COUNTERS_EN
    , .oCycleCount(oCycleCount), .oInstret(oInstret)
`endif
  );

  always #5 iCLK = ~iCLK;

  int nVectors = 0;
  int nMiscompares = 0;
  bit checkEn = 1'b0;

  // Expected architectural state
  longint unsigned mPC, mPCB, mIR, mMDR, mA, mB, mALU, mCyc, mInst;
  localparam longint unsigned TWO32 = 64'h1_0000_0000;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nVectors++;
    if (act !== exp) begin
      nMiscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic modelReset();
    mPC = 32'h0040_0000; mPCB = 32'h0040_0000; mIR = 32'h13;
    mMDR = 0; mA = 0; mB = 0; mALU = 0; mCyc = 0; mInst = 0;
  endtask

  // Next-state rules evaluated from the current expected state and the inputs at the edge.
  task automatic modelEdge();
    longint unsigned target;
    bit takePC;
    takePC = (EscrevePC == 1'b1) || (EscrevePCCond == 1'b1 && iZero == 1'b1);
    target = (OrigPC == 1'b1) ? mALU : iALUResult;
    target = target - (target % 2);
    if (EscrevePCB) mPCB = mPC;
    if (takePC) mPC = target % TWO32;
    if (EscreveIR) begin
      mIR = iMemData;
      mInst = (mInst + 1) % TWO32;
    end
    mMDR = iMemData; mA = iRs1Data; mB = iRs2Data; mALU = iALUResult;
    mCyc = (mCyc + 1) % TWO32;
  endtask

  task automatic tick();
    @(posedge iCLK);
    modelEdge();
    @(negedge iCLK);
  endtask

  task automatic idle();
    EscrevePC = 0; EscrevePCCond = 0; EscreveIR = 0; EscrevePCB = 0; OrigPC = 0; iZero = 0;
  endtask

  always @(negedge iCLK) begin
    if (checkEn) begin
      chk("pc", oPC, mPC[31:0]);
      chk("pcback", oPCBack, mPCB[31:0]);
      chk("ir", oIR, mIR[31:0]);
      chk("mdr", oMDR, mMDR[31:0]);
      chk("a", oA, mA[31:0]);
      chk("b", oB, mB[31:0]);
      chk("aluout", oALUOut, mALU[31:0]);
`ifdef MULTICICLO_COUNTERS_EN
      chk("cycles", oCycleCount, mCyc[31:0]);
      chk("instret", oInstret, mInst[31:0]);
`endif
    end
  end

  initial begin
    idle();
    iALUResult = 0; iMemData = 0; iRs1Data = 0; iRs2Data = 0;
    iRST = 1'b1;
    modelReset();
    repeat (2) @(negedge iCLK);
    chk("rst_pc", oPC, 32'h0040_0000);
    chk("rst_pcback", oPCBack, 32'h0040_0000);
    chk("rst_ir", oIR, 32'h0000_0013);
    chk("rst_a", oA, 32'h0);
    chk("rst_aluout", oALUOut, 32'h0);
    iRST = 1'b0;
    checkEn = 1'b1;

    // Unconditional PC write
    EscrevePC = 1; iALUResult = 32'h0040_0004;
    tick();
    chk("pc_write", oPC, 32'h0040_0004);

    // Branch: load ALUOut target, then not-taken, then taken
    idle(); iALUResult = 32'h0040_0020;
    tick();
    EscrevePCCond = 1; OrigPC = 1; iZero = 0;
    tick();
    chk("branch_not_taken", oPC, 32'h0040_0004);
    iZero = 1; iALUResult = 32'h0000_0999;
    tick();
    chk("branch_taken", oPC, 32'h0040_0020);

    // Fetch edge
    idle(); EscrevePC = 1; iALUResult = 32'h0040_0008;
    tick();
    EscreveIR = 1; EscrevePCB = 1; iMemData = 32'h0050_0093; iALUResult = 32'h0040_000C;
    tick();
    chk("fetch_ir", oIR, 32'h0050_0093);
    chk("fetch_pcback", oPCBack, 32'h0040_0008);
    chk("fetch_pc", oPC, 32'h0040_000C);

    // JALR bit-0 clear
    idle(); EscrevePC = 1; iALUResult = 32'h0040_0011;
    tick();
    chk("jalr_pc", oPC, 32'h0040_0010);

    // Unconditional beats a not-taken conditional
    EscrevePCCond = 1; iZero = 0; iALUResult = 32'h0040_0040;
    tick();
    chk("uncond_wins", oPC, 32'h0040_0040);

    // Holds with enables low; IR must keep the fetched word
    idle();
    for (int i = 0; i < 4; i++) begin
      iMemData = $urandom; iALUResult = $urandom; iRs1Data = $urandom; iRs2Data = $urandom;
      iZero = 1'($urandom_range(0, 1));
      tick();
    end
    chk("ir_hold", oIR, 32'h0050_0093);

    // Wrap / odd targets through both sources
    EscrevePC = 1; iALUResult = 32'hFFFF_FFFF;
    tick();
    chk("pc_top", oPC, 32'hFFFF_FFFE);
    OrigPC = 1; iALUResult = 32'h1234_5679;
    tick();
    chk("pc_from_aluout_odd", oPC, 32'hFFFF_FFFE);

    // Random mix of controls, checked against the model only
    for (int i = 0; i < 40; i++) begin
      EscrevePC = 1'($urandom_range(0, 1)); EscrevePCCond = 1'($urandom_range(0, 1));
      EscreveIR = 1'($urandom_range(0, 1)); EscrevePCB = 1'($urandom_range(0, 1));
      OrigPC = 1'($urandom_range(0, 1)); iZero = 1'($urandom_range(0, 1));
      iALUResult = $urandom; iMemData = $urandom; iRs1Data = $urandom; iRs2Data = $urandom;
      tick();
    end

    // Asynchronous reset between edges discards a pending write
    idle(); iRs1Data = 32'h0000_1234;
    tick();
    chk("a_load", oA, 32'h0000_1234);
    EscrevePC = 1; EscreveIR = 1; iALUResult = 32'h0000_0777; iMemData = 32'hDEAD_BEEF;
    #2;
    iRST = 1'b1;
    modelReset();
    #1;
    chk("async_a", oA, 32'h0);
    chk("async_pc", oPC, 32'h0040_0000);
    chk("async_ir", oIR, 32'h0000_0013);
    @(negedge iCLK);
    iRST = 1'b0;

    // First edge after reset is a normal cycle; EscreveIR pulsed 3 times over 10 edges
    idle();
    for (int i = 0; i < 10; i++) begin
      EscreveIR = (i == 1 || i == 4 || i == 8);
      iMemData = 32'h0000_1000 + i;
      tick();
    end
    chk("ir_after_reset", oIR, 32'h0000_1008);
`ifdef MULTICICLO_COUNTERS_EN
    chk("cycle_count_10", oCycleCount, 32'd10);
    chk("instret_3", oInstret, 32'd3);
`endif

    checkEn = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", nVectors, nMiscompares);
    $finish;
  end

endmodule

// File: doc/multiciclo_datapath_regs.md
MULTICICLO_DATAPATH_REGS -- requirements
Module: multiciclo_datapath_regs

Interface
REQ-001 The block SHALL have a parameter PC_RESET, default 32'h0040_0000, giving the PC reset address (start of the text segment).
REQ-002 Port iCLK  input  1  the single system clock; all state SHALL update on its rising edge.
REQ-003 Port iRST  input  1  asynchronous, active-high reset.
REQ-004 Port EscrevePC  input  1  unconditional PC write enable from the multicycle control.
REQ-005 Port EscrevePCCond  input  1  conditional PC write enable (branch).
REQ-006 Port EscreveIR  input  1  instruction register write enable.
REQ-007 Port EscrevePCB  input  1  PC-backup register write enable.
REQ-008 Port OrigPC  input  1  next-PC source select: 0 = iALUResult, 1 = oALUOut.
REQ-009 Port iZero  input  1  ALU zero flag, same cycle as iALUResult.
REQ-010 Port iALUResult  input  32  combinational ALU output.
REQ-011 Port iMemData  input  32  unified memory read data.
REQ-012 Port iRs1Data, iRs2Data  input  32 each  register-file read data.
REQ-013 Port oPC  output  32  program counter.
REQ-014 Port oPCBack  output  32  PC of the instruction currently in IR.
REQ-015 Port oIR  output  32  instruction register; drives the control unit's iInstruction.
REQ-016 Port oMDR, oA, oB, oALUOut  output  32 each  memory data, operand A, operand B, and ALU result registers.

Function
REQ-017 PC write SHALL occur when EscrevePC = 1 OR (EscrevePCCond = 1 AND iZero = 1).
REQ-018 The written PC value SHALL be iALUResult when OrigPC = 0 and oALUOut when OrigPC = 1, with bit 0 forced to 0 (JALR rule).
REQ-019 When EscrevePC and EscrevePCCond are both 1, the unconditional write SHALL win regardless of iZero.
REQ-020 oPCBack SHALL load the pre-update oPC when EscrevePCB = 1.
- In the same edge where the PC is written, oPCBack SHALL capture the old PC value.
REQ-021 oIR SHALL load iMemData when EscreveIR = 1 and SHALL hold otherwise.
REQ-022 oMDR, oA, oB and oALUOut SHALL load iMemData, iRs1Data, iRs2Data and iALUResult respectively on every clock edge, with no enable.
REQ-023 Every register output SHALL become visible one cycle after its capturing edge; there SHALL be no combinational input-to-output paths.
REQ-024 The PC SHALL wrap modulo 2^32 with no overflow indication.

Reset
REQ-025 While iRST = 1, outputs SHALL be: oPC = PC_RESET, oPCBack = PC_RESET, oIR = 32'h0000_0013 (NOP), and oMDR = oA = oB = oALUOut = 0.
REQ-026 Reset asserted mid-instruction SHALL take effect immediately, without waiting for a clock edge, and SHALL discard any pending write.
REQ-027 The first rising edge after iRST deasserts SHALL be treated as a normal cycle.

Configuration
REQ-028 Macro MULTICICLO_COUNTERS_EN SHALL compile in two extra 32-bit outputs, oCycleCount and oInstret.
- oCycleCount SHALL increment on every edge.
- oInstret SHALL increment on every edge where EscreveIR = 1.
- Both SHALL reset to 0 and wrap at 2^32.
REQ-029 When MULTICICLO_COUNTERS_EN is undefined, these ports and their counters SHALL be absent, and all other behaviour SHALL be identical.

Verification
REQ-030 Reset, then 1 edge with EscrevePC = 1, OrigPC = 0, iALUResult = 0x0040_0004 -> oPC = 0x0040_0004.
REQ-031 Branch: EscrevePCCond = 1, OrigPC = 1, oALUOut = 0x0040_0020, iZero = 0 -> oPC unchanged; repeat with iZero = 1 -> oPC = 0x0040_0020.
REQ-032 Fetch edge with EscreveIR = 1, EscrevePCB = 1, EscrevePC = 1, iMemData = 0x0050_0093, PC = 0x0040_0008 -> oIR = 0x0050_0093, oPCBack = 0x0040_0008, oPC = 0x0040_000C.
REQ-033 JALR target iALUResult = 0x0040_0011 with EscrevePC = 1 -> oPC = 0x0040_0010.
REQ-034 Assert iRST between edges after oA = 0x1234 -> oA = 0 and oPC = 0x0040_0000 immediately; oIR = 0x0000_0013.
REQ-035 With MULTICICLO_COUNTERS_EN defined: 10 edges with EscreveIR pulsed 3 times -> oCycleCount = 10, oInstret = 3.
